// File: rtl/conv_mix_pkg.sv
// rtl/conv_mix_pkg.sv - shared types and constants for the conv_mix_n mixing stage
package conv_mix_pkg;

    localparam logic MODE_SEP = 1'b0;
    localparam logic MODE_SUM = 1'b1;

    localparam int DLY0_DEF   = 10;
    localparam int DLY1_DEF   = 90;
    localparam int FRAME0_DEF = 576;
    localparam int FRAME1_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic int tree_levels(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/add_tree_pipe.sv
// rtl/add_tree_pipe.sv - registered pairwise adder tree with valid pipeline
// CONV_MIX_N_SAT_EN: clamp the wide sum to DW instead of wrapping
module add_tree_pipe import conv_mix_pkg::*; #(
    parameter int CH = 6,
    parameter int DW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [CH*DW-1:0] data_i,
    output logic             valid_o,
    output logic [DW-1:0]    sum_o
);

    localparam int TL = tree_levels(CH);
    localparam int SW = DW + TL;
    localparam int NP = 1 << TL;

    logic [SW-1:0] ext   [NP];
    logic [SW-1:0] lvl_q [TL][NP];
    logic [TL-1:0] vld_q;
    logic [SW-1:0] total;

    // Leaves are padded with zeros to a power of two; adding zero forwards an odd element.
    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ext[i] = '0;
        end
        for (int i = 0; i < CH; i++) begin
            ext[i] = {{TL{data_i[i*DW+DW-1]}}, data_i[i*DW +: DW]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int l = 0; l < TL; l++) begin
                for (int j = 0; j < NP; j++) begin
                    lvl_q[l][j] <= '0;
                end
            end
        end else begin
            vld_q[0] <= valid_i;
            for (int l = 1; l < TL; l++) begin
                vld_q[l] <= vld_q[l-1];
            end
            for (int j = 0; j < NP / 2; j++) begin
                lvl_q[0][j] <= ext[2*j] + ext[2*j+1];
            end
            for (int l = 1; l < TL; l++) begin
                for (int j = 0; j < (NP >> (l + 1)); j++) begin
                    lvl_q[l][j] <= lvl_q[l-1][2*j] + lvl_q[l-1][2*j+1];
                end
            end
        end
    end

    assign total   = lvl_q[TL-1][0];
    assign valid_o = vld_q[TL-1];

`ifdef CONV_MIX_N_SAT_EN
    localparam logic [SW-1:0] SMAX = {{(TL+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [SW-1:0] SMIN = {{(TL+1){1'b1}}, {(DW-1){1'b0}}};

    always_comb begin
        if (!total[SW-1] && (total > SMAX)) begin
            sum_o = {1'b0, {(DW-1){1'b1}}};
        end else if (total[SW-1] && (total < SMIN)) begin
            sum_o = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sum_o = total[DW-1:0];
        end
    end
`else
    assign sum_o = total[DW-1:0];
`endif

endmodule

// File: rtl/conv_mix_n.sv
// rtl/conv_mix_n.sv - post-conv mixing stage: din_ready sequencing, per-channel or summed mix, ReLU, frame done
// CONV_MIX_N_SAT_EN: saturating cross-channel sum (forwarded to add_tree_pipe)
module conv_mix_n import conv_mix_pkg::*; #(
    parameter int CH     = 6,
    parameter int DW     = 32,
    parameter int DLY0   = DLY0_DEF,
    parameter int DLY1   = DLY1_DEF,
    parameter int FRAME0 = FRAME0_DEF,
    parameter int FRAME1 = FRAME1_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [CH-1:0]    in_valid,
    input  logic [CH*DW-1:0] din,
    output logic             din_ready,
    output logic             ovalid,
    output logic [CH*DW-1:0] dout,
    output logic             done,
    output logic             busy
);

    localparam int TL   = tree_levels(CH);
    localparam int FMAX = (FRAME0 > FRAME1) ? FRAME0 : FRAME1;
    localparam int DMAX = (DLY0 > DLY1) ? DLY0 : DLY1;
    localparam int FW   = $clog2(FMAX + 1);
    localparam int DCW  = $clog2(DMAX + 1);

    localparam logic [DCW-1:0] DLAST0 = DCW'(DLY0 - 1);
    localparam logic [DCW-1:0] DLAST1 = DCW'(DLY1 - 1);
    localparam logic [FW-1:0]  FLAST0 = FW'(FRAME0 - 1);
    localparam logic [FW-1:0]  FLAST1 = FW'(FRAME1 - 1);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             ovalid_q;
    logic [CH*DW-1:0] dout_q, dout_d;
    logic [DW-1:0]    dly_q [TL][CH];
    logic [DW-1:0]    lane;
    logic             tree_vld;
    logic [DW-1:0]    tree_sum;
    logic [DCW-1:0]   dlast;
    logic [FW-1:0]    flast;
    logic             last_beat;

    add_tree_pipe #(
        .CH (CH),
        .DW (DW)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .valid_i (&in_valid),
        .data_i  (din),
        .valid_o (tree_vld),
        .sum_o   (tree_sum)
    );

    // Per-channel lanes are delayed by the tree depth so both modes share latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < TL; s++) begin
                for (int i = 0; i < CH; i++) begin
                    dly_q[s][i] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                dly_q[0][i] <= din[i*DW +: DW];
            end
            for (int s = 1; s < TL; s++) begin
                for (int i = 0; i < CH; i++) begin
                    dly_q[s][i] <= dly_q[s-1][i];
                end
            end
        end
    end

    always_comb begin
        dout_d = '0;
        lane   = '0;
        for (int i = 0; i < CH; i++) begin
            lane = (mode_q == MODE_SUM) ? tree_sum : dly_q[TL-1][i];
            dout_d[i*DW +: DW] = lane[DW-1] ? '0 : lane;
        end
    end

    assign dlast     = (mode_q == MODE_SUM) ? DLAST1 : DLAST0;
    assign flast     = (mode_q == MODE_SUM) ? FLAST1 : FLAST0;
    assign last_beat = (state_q == ST_RUN) && ovalid_q && (fcnt_q == flast);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dcnt_d  = dcnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            ST_IDLE: begin
                mode_d = mode;
                dcnt_d = '0;
                fcnt_d = '0;
                if (start) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!start) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == dlast) begin
                    state_d = ST_RUN;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // The final beat wins over a simultaneous start drop.
                if (last_beat) begin
                    state_d = ST_DONE;
                    fcnt_d  = '0;
                end else if (!start) begin
                    state_d = ST_IDLE;
                    fcnt_d  = '0;
                end else if (ovalid_q) begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SEP;
            dcnt_q   <= '0;
            fcnt_q   <= '0;
            ovalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dcnt_q   <= dcnt_d;
            fcnt_q   <= fcnt_d;
            ovalid_q <= tree_vld;
            dout_q   <= dout_d;
        end
    end

    assign din_ready = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = last_beat;
    assign ovalid    = ovalid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_conv_mix_n.sv
// tb/tb_conv_mix_n.sv - self-checking bench for conv_mix_n against a behavioural model
module tb_conv_mix_n;

    localparam int CH     = 6;
    localparam int DW     = 32;
    localparam int DLY0   = 10;
    localparam int DLY1   = 90;
    localparam int FRAME0 = 576;
    localparam int FRAME1 = 64;
    localparam int L      = $clog2(CH) + 1;
    localparam int W      = CH * DW;
    localparam longint LMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint LMIN = -(longint'(1) <<< (DW - 1));

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [CH-1:0] in_valid;
    logic [W-1:0]  din;
    logic          din_ready;
    logic          ovalid;
    logic [W-1:0]  dout;
    logic          done;
    logic          busy;

    always #5 clk = ~clk;

    conv_mix_n #(
        .CH(CH), .DW(DW), .DLY0(DLY0), .DLY1(DLY1), .FRAME0(FRAME0), .FRAME1(FRAME1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .din       (din),
        .din_ready (din_ready),
        .ovalid    (ovalid),
        .dout      (dout),
        .done      (done),
        .busy      (busy)
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } ent_t;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     ph       = 0;   // 0 idle, 1 waiting, 2 running, 3 done
    int     waited   = 0;
    int     beats    = 0;
    logic   m_mode   = 1'b0;
    logic   cur_ov   = 1'b0;
    logic   saw_done = 1'b0;
    ent_t   pipe_q[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_out(input logic m, input logic [W-1:0] d);
        logic [W-1:0]         r;
        logic signed [DW-1:0] lane;
        longint               s;
        r = '0;
        s = 0;
        if (m == 1'b0) begin
            for (int i = 0; i < CH; i++) begin
                lane = d[i*DW +: DW];
                r[i*DW +: DW] = (lane < 0) ? '0 : lane;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                s += longint'(signed'(d[i*DW +: DW]));
            end
`ifdef CONV_MIX_N_SAT_EN
            if (s > LMAX) s = LMAX;
            if (s < LMIN) s = LMIN;
`endif
            lane = s[DW-1:0];
            if (lane < 0) lane = '0;
            for (int i = 0; i < CH; i++) begin
                r[i*DW +: DW] = lane;
            end
        end
        return r;
    endfunction

    // One clock: advance the model over the coming edge, then compare after it.
    task automatic step();
        ent_t e;
        ent_t o;
        int   dly;
        int   frm;
        logic exp_done;
        o = '0;
        if (rst) begin
            ph = 0; waited = 0; beats = 0; m_mode = 1'b0;
            pipe_q.delete();
            for (int i = 0; i < L - 1; i++) pipe_q.push_back('0);
        end else begin
            dly = m_mode ? DLY1 : DLY0;
            frm = m_mode ? FRAME1 : FRAME0;
            case (ph)
                0: begin
                    m_mode = mode;
                    if (start) begin ph = 1; waited = 0; end
                end
                1: begin
                    if (!start) ph = 0;
                    else begin
                        waited++;
                        if (waited == dly) ph = 2;
                    end
                end
                2: begin
                    if (cur_ov && beats == frm - 1) begin ph = 3; beats = 0; end
                    else begin
                        if (cur_ov) beats++;
                        if (!start) begin ph = 0; beats = 0; end
                    end
                end
                default: if (!start) ph = 0;
            endcase
            e.v = &in_valid;
            e.d = model_out(m_mode, din);
            pipe_q.push_back(e);
            o = pipe_q.pop_front();
        end
        cur_ov   = o.v;
        frm      = m_mode ? FRAME1 : FRAME0;
        exp_done = (ph == 2) && o.v && (beats == frm - 1);
        @(posedge clk);
        @(negedge clk);
        check("ovalid", W'(ovalid), W'(o.v));
        if (o.v || rst) check("dout", dout, o.d);
        check("done", W'(done), W'(exp_done));
        check("din_ready", W'(din_ready), W'(ph == 2));
        check("busy", W'(busy), W'(ph != 0));
        if (done) saw_done = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = '0;
        repeat (n) step();
    endtask

    task automatic rand_beat();
        int r;
        r = $urandom_range(0, 99);
        for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 1) == 1) din[i*DW +: DW] = $urandom();
            else din[i*DW +: DW] = DW'($urandom_range(0, 200)) - DW'(100);
        end
        if (r < 70) in_valid = '1;
        else if (r < 80) begin in_valid = '1; in_valid[CH-1] = 1'b0; end
        else if (r < 90) in_valid = CH'($urandom());
        else in_valid = '0;
    endtask

    // stop_at < 0: run to done; otherwise abort (start drop or reset) after that many beats.
    task automatic run_frame(input logic m, input int stop_at, input logic by_rst);
        int g;
        saw_done = 1'b0;
        mode = m; start = 1'b1; in_valid = '0;
        step();
        g = 0;
        while (ph != 2 && g < 200) begin rand_beat(); step(); g++; end
        g = 0;
        while (ph == 2 && g < 4000) begin
            if (stop_at >= 0 && beats >= stop_at) break;
            rand_beat(); step(); g++;
        end
        if (stop_at >= 0) begin
            if (by_rst) rst = 1'b1;
            start = 1'b0; in_valid = '0;
            step();
            rst = 1'b0;
            idle(L + 1);
            check("no_done_on_abort", W'(saw_done), W'(0));
        end else begin
            check("done_seen", W'(saw_done), W'(1));
            idle(3);
        end
        start = 1'b0;
        idle(L + 2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_valid = '0; din = '0;
        repeat (3) step();
        rst = 1'b0;

        start = 1'b1; mode = 1'b0; idle(DLY0 + 3);
        start = 1'b0; idle(3);
        mode = 1'b1; start = 1'b1; idle(DLY1 + 3);
        start = 1'b0; mode = 1'b0; idle(L + 2);

        start = 1'b1; idle(6);
        start = 1'b0; idle(DLY0 + 5);

        din = {DW'(100), DW'(-1), DW'(0), DW'(7), DW'(-3), DW'(5)};
        in_valid = '1; step();
        in_valid = 6'b011111; step();
        idle(L + 1);

        mode = 1'b1; idle(L);
        din = {DW'(-20), DW'(5), DW'(4), DW'(3), DW'(2), DW'(1)};
        in_valid = '1; step();
        din = {DW'(6), DW'(5), DW'(4), DW'(3), DW'(2), DW'(1)};
        step();
        din = {CH{32'h7FFF_FFFF}};
        step();
        din = {CH{32'h8000_0000}};
        step();
        idle(L + 1);
        mode = 1'b0; idle(L);

        run_frame(1'b1, -1, 1'b0);
        run_frame(1'b0, -1, 1'b0);
        run_frame(1'b1, 20, 1'b0);
        run_frame(1'b0, 300, 1'b1);
        run_frame(1'b0, -1, 1'b0);
        run_frame(1'b1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
